// File: rtl/decoder_pkg.sv
// Shared definitions for the step decoder: mode encoding and a generic
// one-hot helper used by the combinational decode stage.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SEQ    = 1'b1;

    localparam int MAX_IDX_W = 8;
    localparam int MAX_OUT   = 1 << MAX_IDX_W;

    // Indices at or beyond width yield all-zero rather than aliasing.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_IDX_W-1:0] idx,
                                                  input int unsigned width);
        logic [MAX_OUT-1:0] r;
        r = '0;
        if (32'(idx) < width) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Purely combinational index -> one-hot decode with 2**SEL_W outputs.
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      idx,
    output logic [(2**SEL_W)-1:0] onehot_out
);

    localparam int N_OUT = 2 ** SEL_W;

    assign onehot_out = N_OUT'(onehot(MAX_IDX_W'(idx), N_OUT));

endmodule

// File: rtl/step_decoder.sv
// Registered one-hot decoder with direct select decode and a wrapping
// step-sequence mode for control-path timing signals.
module step_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int LAST  = 2**SEL_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  clear,
    input  logic                  hold,
    output logic [(2**SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      step,
    output logic                  valid,
    output logic                  wrap
);

    localparam int N_OUT = 2 ** SEL_W;

    if (LAST < 0 || LAST >= N_OUT) begin : g_last_check
        $fatal(1, "step_decoder: LAST out of range 0..N_OUT-1");
    end

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);

    typedef enum logic [1:0] {
        OUT_ZERO,
        OUT_KEEP,
        OUT_LOAD
    } out_op_t;

    logic [SEL_W-1:0] step_q, step_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    out_op_t          out_op;
    logic [N_OUT-1:0] dec_out;

    always_comb begin
        step_d  = step_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        out_op  = OUT_KEEP;
        if (!en) begin
            valid_d = 1'b0;
            out_op  = OUT_ZERO;
        end else if (clear) begin
            step_d  = '0;
            valid_d = 1'b1;
            out_op  = OUT_LOAD;
        end else if (mode == MODE_DIRECT) begin
            step_d  = sel;
            valid_d = 1'b1;
            out_op  = OUT_LOAD;
        end else if (!hold) begin
            // Out-of-range steps (from a direct load) restart silently at 0.
            if (step_q == LAST_IDX) begin
                step_d = '0;
                wrap_d = 1'b1;
            end else if (step_q > LAST_IDX) begin
                step_d = '0;
            end else begin
                step_d = step_q + 1'b1;
            end
            valid_d = 1'b1;
            out_op  = OUT_LOAD;
        end
    end

    onehot_decoder #(.SEL_W(SEL_W)) u_dec (
        .idx        (step_d),
        .onehot_out (dec_out)
    );

    always_comb begin
        out_d = out_q;
        case (out_op)
            OUT_ZERO: out_d = '0;
            OUT_LOAD: out_d = dec_out;
            default:  out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            step_q  <= step_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out   = out_q;
    assign step  = step_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: doc/step_decoder.md
Name: step_decoder

Overview:
- Parametrised registered one-hot decoder for the processor control path, with two modes.
- Direct mode decodes a select field, e.g. register-file or bus-source select.
- Sequence mode runs an internal step counter and drives one-hot timing signals T0..T(LAST) for the control FSM.
- Replaces the fixed 3-to-8 combinational decode; adds enable, clear, hold, load-from-select and a wrap pulse.

Parameters:
- SEL_W, 3, select/step width; N_OUT = 2**SEL_W outputs (localparam, not overridable).
- LAST, 2**SEL_W-1, final step index in sequence mode; legal range 0..N_OUT-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; 0 forces out to zero
- mode  in  1  0 = direct decode of sel; 1 = sequence (counter) mode
- sel  in  SEL_W  select index in direct mode
- clear  in  1  synchronous: step <= 0, out <= one-hot bit 0
- hold  in  1  sequence mode only: freeze step and out
- out  out  N_OUT  registered one-hot (or all-zero) decode
- step  out  SEL_W  current step/index register
- valid  out  1  registered, equals |out
- wrap  out  1  one-cycle pulse, sequence advanced LAST -> 0

Behaviour:
- Reset (async assert, sync release): out=0, step=0, valid=0, wrap=0.
- All outputs are registered. Latency is 1 cycle from inputs to out/step/valid/wrap.
- Per-cycle priority, highest first: rst > en=0 > clear > mode.
- en=0: out<=0, valid<=0, wrap<=0; step holds its value.
- en=1, clear=1 (either mode): step<=0, out<=1 (bit 0), valid<=1, wrap<=0. hold is ignored.
- en=1, mode=0: step<=sel, out<=1<<sel, valid<=1, wrap<=0. hold is ignored. Every sel value decodes; no default/zero case.
- en=1, mode=1, hold=1: step, out and valid keep their values; wrap<=0.
- en=1, mode=1, hold=0: next step is 0 if step==LAST, else step+1.
  - out<=1<<next, valid<=1.
  - wrap<=1 only when step==LAST, else 0.
- Sequence mode advances from the current step. It does not depend on whether out was valid.
  - First sequence cycle after reset or en=0: step 0 -> out bit 1.
  - clear first to start at T0.
- step > LAST on entry to sequence mode (e.g. loaded in direct mode): next step is 0, wrap<=0.
- LAST = 0: step stays 0, out stays bit 0, wrap pulses every advancing cycle.
- Mode switch: direct load then mode=1 continues from the loaded index.
  - Example: sel=2 loaded, next sequence cycle gives step 3.
- Invariant: out is exactly one-hot (when valid=1) or all-zero (valid=0). out == (1<<step) whenever valid=1.
- LAST outside 0..N_OUT-1 is illegal; elaboration-time assertion.
- Reset asserted mid-sequence: all outputs go to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package decoder_pkg:
  - mode encoding constants MODE_DIRECT=1'b0, MODE_SEQ=1'b1;
  - function onehot(idx, width).
- One natural sub-module: onehot_decoder #(SEL_W). Purely combinational, in -> 2**SEL_W one-hot, no enable. It is instantiated on the next-step value feeding the out register.

Test Plan (SEL_W=3 unless noted):
- Reset: assert rst mid-run with out=8'h10 -> out=0, step=0, valid=0 immediately, no clock edge needed.
- Direct sweep: en=1, mode=0, sel=0..7 one per cycle -> next cycle out=01,02,04,...,80; step=sel; valid=1; wrap=0.
- Sequence LAST=3: clear, then mode=1 for 5 cycles -> out 01,02,04,08,01,02. wrap=1 only on the 08->01 cycle.
- Hold/clear: sequence at step 2, hold=1 for 3 cycles -> out stays 04. Then clear=1 with hold=1 -> out=01, step=0.
- Enable and load, LAST=3: en=0 -> out=0, valid=0, step unchanged (2). Then mode=0, sel=5 -> out=20. Then mode=1 -> step 0, out=01, wrap=0.
- Default LAST=7: run 9 sequence cycles -> step wraps 7->0 with a single wrap pulse; out is always one-hot.
